// File: rtl/dioptase_pkg.sv
// Shared core parameters for the register file and its read ports.
package dioptase_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    // True when an already-qualified write targets a nonzero read address.
    function automatic logic wr_hit(input logic we, input logic [AW-1:0] waddr,
                                    input logic [AW-1:0] addr);
        return we && (waddr == addr) && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: held address, write-first bypass and stall-hold refresh.
module regfile_read_port
    import dioptase_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            update,
    input  logic            stall,
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] rf_val,
    input  logic            wr1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic            wr2,
    input  logic [AW-1:0]   waddr2,
    input  logic [XLEN-1:0] wdata2,
    output logic [XLEN-1:0] rdata
);

    logic [AW-1:0]   held_q, held_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    // Port 1 outranks port 2 both for fresh reads and for refreshing a held read.
    always_comb begin
        held_d  = held_q;
        rdata_d = rdata_q;
        if (update) begin
            if (!stall) begin
                held_d = raddr;
                if (raddr == REG_ZERO) begin
                    rdata_d = '0;
                end else if (wr_hit(wr1, waddr1, raddr)) begin
                    rdata_d = wdata1;
                end else if (wr_hit(wr2, waddr2, raddr)) begin
                    rdata_d = wdata2;
                end else begin
                    rdata_d = rf_val;
                end
            end else begin
                if (wr_hit(wr1, waddr1, held_q)) begin
                    rdata_d = wdata1;
                end else if (wr_hit(wr2, waddr2, held_q)) begin
                    rdata_d = wdata2;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q  <= '0;
            rdata_q <= '0;
        end else begin
            held_q  <= held_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_2w.sv
// 32x32 register file, two write ports, two registered bypassing read ports.
// Optional debug read port enabled by defining REGFILE_DEBUG_PORT_EN.
module regfile_2w
    import dioptase_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            halt,
    input  logic            stall,
    input  logic            we1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wdata1,
    input  logic            we2,
    input  logic [AW-1:0]   waddr2,
    input  logic [XLEN-1:0] wdata2,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]   dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
`endif
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic update_c;
    logic wr1_c;
    logic wr2_c;

    assign update_c = clk_en && !halt;
    assign wr1_c    = update_c && we1 && (waddr1 != REG_ZERO);
    assign wr2_c    = update_c && we2 && (waddr2 != REG_ZERO);

    // Port 1 applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr2_c) begin
            regs_d[waddr2] = wdata2;
        end
        if (wr1_c) begin
            regs_d[waddr1] = wdata1;
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port u_port_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (update_c),
        .stall  (stall),
        .raddr  (raddr_a),
        .rf_val (regs_q[raddr_a]),
        .wr1    (wr1_c),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .wr2    (wr2_c),
        .waddr2 (waddr2),
        .wdata2 (wdata2),
        .rdata  (rdata_a)
    );

    regfile_read_port u_port_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .update (update_c),
        .stall  (stall),
        .raddr  (raddr_b),
        .rf_val (regs_q[raddr_b]),
        .wr1    (wr1_c),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .wr2    (wr2_c),
        .waddr2 (waddr2),
        .wdata2 (wdata2),
        .rdata  (rdata_b)
    );

`ifdef REGFILE_DEBUG_PORT_EN
    // Raw storage view for the halt-mode debugger; deliberately unbypassed.
    assign dbg_rdata = (dbg_raddr == REG_ZERO) ? '0 : regs_q[dbg_raddr];
`endif

endmodule
